ascon_cmd_decoder: RTL and testbench

- Synthesizable receiver for the INS/DAT instruction-word stream used to exercise ascon_core.
- Accepts 32-bit words over a valid/ready stream, for example from a UART or bus bridge.
- Decodes instruction words and forwards data words to the core's key/bdi interfaces with the correct type, eot and eoi.
- Holds the persistent mode inputs (decrypt_in, hash_in) and drives bdo_ready and msg_auth_ready.
- Sits directly in front of ascon_core in FPGA/SoC top levels.

---
 rtl/ascon_cmd_decoder_pkg.sv | 47 ++++
 rtl/ascon_cmd_decoder_word_buf.sv | 52 +++++
 rtl/ascon_cmd_decoder.sv | 183 ++++++++++++++++++
 tb/tb_ascon_cmd_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ascon_cmd_decoder_pkg
// Brief    : Opcodes, data-type codes, widths and state encoding shared by the
//            instruction/data stream decoder in front of ascon_core.
// Revision : 1.0 - initial release
// ============================================================================
package ascon_cmd_decoder_pkg;

    localparam int unsigned CCW_BITS  = 32;
    localparam int unsigned CCSW_BITS = 32;

    localparam logic [3:0] OP_ENC      = 4'h0;
    localparam logic [3:0] OP_DEC      = 4'h1;
    localparam logic [3:0] OP_HASH     = 4'h2;
    localparam logic [3:0] OP_LD_KEY   = 4'h3;
    localparam logic [3:0] OP_LD_NONCE = 4'h4;
    localparam logic [3:0] OP_LD_AD    = 4'h5;
    localparam logic [3:0] OP_LD_MSG   = 4'h6;
    localparam logic [3:0] OP_LD_TAG   = 4'h7;

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_MSG   = 4'h4;
    localparam logic [3:0] D_TAG   = 4'h5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_e;

    function automatic logic [3:0] op_to_type(input logic [3:0] op);
        logic [3:0] t;
        t = D_NULL;
        case (op)
            OP_LD_NONCE: t = D_NONCE;
            OP_LD_AD:    t = D_AD;
            OP_LD_MSG:   t = D_MSG;
            OP_LD_TAG:   t = D_TAG;
            default:     t = D_NULL;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_cmd_decoder_word_buf.sv
`default_nettype none
// ============================================================================
// Module   : ascon_word_buf
// Brief    : One-deep valid/ready holding register carrying a data word plus
//            its last/null side tags; fill and drain may coincide.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_word_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fill_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         null_i,
    input  logic         drain_i,
    output logic         full_o,
    output logic [W-1:0] data_o,
    output logic         last_o,
    output logic         null_o
);

    logic         full_q;
    logic [W-1:0] data_q;
    logic         last_q;
    logic         null_q;

    // A fill wins over a drain, so refill-while-draining keeps the buffer full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            null_q <= 1'b0;
        end else if (fill_i) begin
            full_q <= 1'b1;
            data_q <= data_i;
            last_q <= last_i;
            null_q <= null_i;
        end else if (drain_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign last_o = last_q;
    assign null_o = null_q;

endmodule
`default_nettype wire

// File: rtl/ascon_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ascon_cmd_decoder
// Brief    : Decodes the INS/DAT word stream into ascon_core key/bdi traffic,
//            mode inputs and output-side ready signals.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_cmd_decoder
    import ascon_cmd_decoder_pkg::*;
#(
    parameter int CCW  = CCW_BITS,
    parameter int CCSW = CCSW_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     cmd_data,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    output logic [CCSW-1:0] key,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [CCW-1:0]  bdi,
    output logic            bdi_valid,
    input  logic            bdi_ready,
    output logic [3:0]      bdi_type,
    output logic            bdi_eot,
    output logic            bdi_eoi,
    output logic            decrypt_in,
    output logic            hash_in,
    input  logic            bdo_valid,
    input  logic [3:0]      bdo_type,
    output logic            bdo_ready,
    output logic            msg_auth_ready,
    output logic            cmd_err,
    output logic            busy
);

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic        eoi_q, eoi_d;
    logic [22:0] cnt_q, cnt_d;
    logic        null_q, null_d;
    logic        decrypt_q, decrypt_d;
    logic        hash_q, hash_d;
    logic        err_q, err_d;

    logic        ready_int;
    logic        buf_fill;
    logic        buf_full;
    logic [31:0] buf_data;
    logic        buf_last;
    logic        buf_null;
    logic        accept;
    logic        key_sel;
    logic        op_active;

    logic [3:0]  ins_op;
    logic [23:0] ins_len;
    logic [22:0] ins_cnt;
    logic [2:0]  unused_flags;

    assign ins_op       = cmd_data[31:28];
    assign ins_len      = cmd_data[23:0];
    assign unused_flags = cmd_data[27:25];
    // Round-up division by four without a wider intermediate.
    assign ins_cnt      = {1'b0, ins_len[23:2]} + {22'd0, |ins_len[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= 4'h0;
            eoi_q     <= 1'b0;
            cnt_q     <= '0;
            null_q    <= 1'b0;
            decrypt_q <= 1'b0;
            hash_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            eoi_q     <= eoi_d;
            cnt_q     <= cnt_d;
            null_q    <= null_d;
            decrypt_q <= decrypt_d;
            hash_q    <= hash_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        eoi_d     = eoi_q;
        cnt_d     = cnt_q;
        null_d    = null_q;
        decrypt_d = decrypt_q;
        hash_d    = hash_q;
        err_d     = err_q;
        ready_int = 1'b0;
        buf_fill  = 1'b0;
        case (state_q)
            IDLE: begin
                // Waiting for an empty buffer keeps op_q valid for the word still queued.
                ready_int = ~buf_full;
                if (cmd_valid && ready_int) begin
                    case (ins_op)
                        OP_ENC: begin
                            decrypt_d = 1'b0;
                            hash_d    = 1'b0;
                        end
                        OP_DEC: begin
                            decrypt_d = 1'b1;
                            hash_d    = 1'b0;
                        end
                        OP_HASH: begin
                            decrypt_d = 1'b0;
                            hash_d    = 1'b1;
                        end
                        OP_LD_KEY, OP_LD_NONCE, OP_LD_AD, OP_LD_MSG, OP_LD_TAG: begin
                            op_d    = ins_op;
                            eoi_d   = cmd_data[24];
                            null_d  = (ins_len == 24'd0);
                            cnt_d   = (ins_len == 24'd0) ? 23'd1 : ins_cnt;
                            state_d = DATA;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            DATA: begin
                ready_int = ~buf_full | accept;
                if (cmd_valid && ready_int) begin
                    buf_fill = 1'b1;
                    cnt_d    = cnt_q - 23'd1;
                    if (cnt_q == 23'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    ascon_word_buf #(
        .W (32)
    ) u_word_buf (
        .clk     (clk),
        .rst     (rst),
        .fill_i  (buf_fill),
        .data_i  (cmd_data),
        .last_i  (cnt_q == 23'd1),
        .null_i  (null_q),
        .drain_i (accept),
        .full_o  (buf_full),
        .data_o  (buf_data),
        .last_o  (buf_last),
        .null_o  (buf_null)
    );

    assign key_sel   = buf_full & (op_q == OP_LD_KEY);
    assign key_valid = key_sel;
    assign key       = key_sel ? buf_data : '0;
    assign bdi_valid = buf_full & (op_q != OP_LD_KEY);
    assign bdi       = bdi_valid ? buf_data : '0;
    assign bdi_type  = (bdi_valid & ~buf_null) ? op_to_type(op_q) : D_NULL;
    assign bdi_eot   = bdi_valid & buf_last & ~buf_null;
    assign bdi_eoi   = bdi_eot & eoi_q;

    assign accept    = (key_valid & key_ready) | (bdi_valid & bdi_ready);
    // The ready output reads 0 for the whole time reset is asserted.
    assign cmd_ready = ready_int & ~rst;

    assign op_active      = (state_q == DATA) | buf_full;
    assign bdo_ready      = (op_active & (op_q == OP_LD_MSG)) | (bdo_valid & (bdo_type == D_TAG));
    assign msg_auth_ready = op_active & (op_q == OP_LD_TAG);

    assign decrypt_in = decrypt_q;
    assign hash_in    = hash_q;
    assign cmd_err    = err_q;
    assign busy       = (state_q != IDLE) | buf_full;

endmodule
`default_nettype wire

// File: tb/tb_ascon_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_cmd_decoder
// Brief    : Directed self-checking bench for ascon_cmd_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_cmd_decoder;
    import ascon_cmd_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] key;
    logic        key_valid;
    logic        key_ready;
    logic [31:0] bdi;
    logic        bdi_valid;
    logic        bdi_ready;
    logic [3:0]  bdi_type;
    logic        bdi_eot;
    logic        bdi_eoi;
    logic        decrypt_in;
    logic        hash_in;
    logic        bdo_valid;
    logic [3:0]  bdo_type;
    logic        bdo_ready;
    logic        msg_auth_ready;
    logic        cmd_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ascon_cmd_decoder #(
        .CCW  (32),
        .CCSW (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_data       (cmd_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .key            (key),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .bdi            (bdi),
        .bdi_valid      (bdi_valid),
        .bdi_ready      (bdi_ready),
        .bdi_type       (bdi_type),
        .bdi_eot        (bdi_eot),
        .bdi_eoi        (bdi_eoi),
        .decrypt_in     (decrypt_in),
        .hash_in        (hash_in),
        .bdo_valid      (bdo_valid),
        .bdo_type       (bdo_type),
        .bdo_ready      (bdo_ready),
        .msg_auth_ready (msg_auth_ready),
        .cmd_err        (cmd_err),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] fl, input logic [23:0] len);
        return {op, fl, len};
    endfunction

    logic [31:0] kw [4];
    logic [31:0] aw [2];
    logic [31:0] mw [3];

    initial begin
        kw = '{32'h0001_0203, 32'h0405_0607, 32'h0809_0A0B, 32'h0C0D_0E0F};
        aw = '{32'h1122_3344, 32'h5500_0000};
        mw = '{32'hA0A1_A2A3, 32'hB0B1_B2B3, 32'hC0C1_C2C3};

        rst = 1'b1; cmd_data = '0; cmd_valid = 1'b0; key_ready = 1'b0;
        bdi_ready = 1'b0; bdo_valid = 1'b0; bdo_type = 4'h0;
        #12;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_bdi_valid", {31'd0, bdi_valid}, 32'd0);
        chk("rst_bdi_type",  {28'd0, bdi_type}, {28'd0, D_NULL});
        chk("rst_modes",     {30'd0, decrypt_in, hash_in}, 32'd0);
        chk("rst_err_busy",  {30'd0, cmd_err, busy}, 32'd0);
        chk("rst_key_bdi",   key | bdi, 32'd0);
        rst = 1'b0;
        tick();

        // Key load: four words streamed back-to-back.
        cmd_valid = 1'b1; cmd_data = ins(OP_LD_KEY, 4'h0, 24'd16); key_ready = 1'b1;
        #1 chk("key_ins_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                cmd_valid = 1'b1; cmd_data = kw[i];
            end else begin
                cmd_valid = 1'b0;
            end
            #1;
            if (i < 4) chk($sformatf("key_cmd_ready%0d", i), {31'd0, cmd_ready}, 32'd1);
            chk($sformatf("key_valid%0d", i), {31'd0, key_valid}, {31'd0, i > 0});
            if (i > 0) chk($sformatf("key_word%0d", i - 1), key, kw[i-1]);
            chk($sformatf("key_no_bdi%0d", i), {31'd0, bdi_valid}, 32'd0);
            tick();
        end
        chk("key_drained", {30'd0, key_valid, busy}, 32'd0);

        // Associated data, len=5 -> two words.
        bdi_ready = 1'b1;
        cmd_valid = 1'b1; cmd_data = ins(OP_LD_AD, 4'h0, 24'd5);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                cmd_valid = 1'b1; cmd_data = aw[i];
            end else begin
                cmd_valid = 1'b0;
            end
            #1;
            chk($sformatf("ad_valid%0d", i), {31'd0, bdi_valid}, {31'd0, i > 0});
            if (i > 0) begin
                chk($sformatf("ad_word%0d", i - 1), bdi, aw[i-1]);
                chk($sformatf("ad_type%0d", i - 1), {28'd0, bdi_type}, {28'd0, D_AD});
                chk($sformatf("ad_eot%0d", i - 1), {31'd0, bdi_eot}, {31'd0, i == 2});
                chk($sformatf("ad_eoi%0d", i - 1), {31'd0, bdi_eoi}, 32'd0);
            end
            tick();
        end

        // Empty message with eoi requested: one null word.
        cmd_valid = 1'b1; cmd_data = ins(OP_LD_MSG, 4'h1, 24'd0);
        tick();
        cmd_data = 32'hDEAD_BEEF;
        #1 chk("null_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("null_valid", {31'd0, bdi_valid}, 32'd1);
        chk("null_word", bdi, 32'hDEAD_BEEF);
        chk("null_type", {28'd0, bdi_type}, {28'd0, D_NULL});
        chk("null_eot_eoi", {30'd0, bdi_eot, bdi_eoi}, 32'd0);
        chk("null_bdo_ready", {31'd0, bdo_ready}, 32'd1);
        tick();
        chk("null_after", {30'd0, bdo_ready, bdi_valid}, 32'd0);

        // Message of three words with a three-cycle downstream stall.
        cmd_valid = 1'b1; cmd_data = ins(OP_LD_MSG, 4'h0, 24'd12);
        tick();
        cmd_data = mw[0];
        tick();
        cmd_data = mw[1]; bdi_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall_ready%0d", i), {31'd0, cmd_ready}, 32'd0);
            chk($sformatf("stall_bdi%0d", i), bdi, mw[0]);
            chk($sformatf("stall_valid%0d", i), {31'd0, bdi_valid}, 32'd1);
            tick();
        end
        bdi_ready = 1'b1;
        #1;
        chk("resume_ready", {31'd0, cmd_ready}, 32'd1);
        chk("resume_bdi0", bdi, mw[0]);
        tick();
        cmd_data = mw[2];
        #1;
        chk("msg_bdi1", bdi, mw[1]);
        chk("msg_eot1", {31'd0, bdi_eot}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("msg_bdi2", bdi, mw[2]);
        chk("msg_type2", {28'd0, bdi_type}, {28'd0, D_MSG});
        chk("msg_eot2", {31'd0, bdi_eot}, 32'd1);
        chk("msg_bdo_ready", {31'd0, bdo_ready}, 32'd1);
        tick();
        chk("msg_done", {30'd0, bdi_valid, busy}, 32'd0);

        // Tag load with eoi: msg_auth_ready spans the command.
        cmd_valid = 1'b1; cmd_data = ins(OP_LD_TAG, 4'h1, 24'd4);
        tick();
        cmd_data = 32'h7A67_0001;
        #1 chk("tag_auth_data", {31'd0, msg_auth_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("tag_type", {28'd0, bdi_type}, {28'd0, D_TAG});
        chk("tag_eot_eoi", {30'd0, bdi_eot, bdi_eoi}, 32'd3);
        chk("tag_auth_buf", {31'd0, msg_auth_ready}, 32'd1);
        tick();
        chk("tag_auth_idle", {31'd0, msg_auth_ready}, 32'd0);
        bdo_valid = 1'b1; bdo_type = D_TAG;
        #1 chk("bdo_tag_ready", {31'd0, bdo_ready}, 32'd1);
        bdo_type = D_MSG;
        #1 chk("bdo_msg_idle", {31'd0, bdo_ready}, 32'd0);
        bdo_valid = 1'b0;

        // Mode instructions and an unknown opcode.
        cmd_valid = 1'b1; cmd_data = ins(OP_DEC, 4'h0, 24'd0);
        tick();
        chk("dec_modes", {30'd0, decrypt_in, hash_in}, 32'd2);
        cmd_data = ins(OP_HASH, 4'h0, 24'd0);
        tick();
        chk("hash_modes", {30'd0, decrypt_in, hash_in}, 32'd1);
        cmd_data = ins(4'hF, 4'h0, 24'd8);
        tick();
        chk("bad_op_err", {31'd0, cmd_err}, 32'd1);
        chk("bad_op_idle", {31'd0, busy}, 32'd0);
        cmd_data = ins(OP_ENC, 4'h0, 24'd0);
        tick();
        chk("err_sticky", {31'd0, cmd_err}, 32'd1);
        chk("enc_modes", {30'd0, decrypt_in, hash_in}, 32'd0);
        chk("enc_no_data", {30'd0, busy, bdi_valid}, 32'd0);

        // Reset in the middle of a key load.
        cmd_data = ins(OP_LD_KEY, 4'h0, 24'd16); key_ready = 1'b0;
        tick();
        cmd_data = kw[0];
        tick();
        key_ready = 1'b1; cmd_data = kw[1];
        tick();
        chk("mid_key_busy", {31'd0, busy}, 32'd1);
        cmd_valid = 1'b0; rst = 1'b1;
        #1;
        chk("mid_rst_outs", {28'd0, key_valid, bdi_valid, cmd_ready, busy}, 32'd0);
        chk("mid_rst_key", key, 32'd0);
        chk("mid_rst_err", {31'd0, cmd_err}, 32'd0);
        tick();
        rst = 1'b0;
        cmd_valid = 1'b1; cmd_data = ins(OP_DEC, 4'h0, 24'd0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("post_rst_decode", {31'd0, decrypt_in}, 32'd1);
        chk("post_rst_nokey", {30'd0, key_valid, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
